// File: rtl/fifo_rd_port.sv
// Read-side engine of the 16-entry ECC FIFO: issues reads, SECDED-decodes the
// returned (22,16) codewords and streams them out through a 2-entry buffer.
module fifo_rd_port #(
  parameter int DATA_W = 16,
  parameter int CODE_W = 22,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [CODE_W-1:0] mem_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sbe,
  output logic              m_dbe,
  output logic [CNT_W-1:0]  sbe_count,
  output logic [CNT_W-1:0]  dbe_count
);

  // Positions 1..21 whose index has bit k set feed syndrome bit k.
  function automatic logic [CODE_W-1:0] cover_mask(input int k);
    cover_mask = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (((i >> k) & 1) == 1) cover_mask = cover_mask | (CODE_W'(1) << i);
    end
  endfunction

  // Data bits occupy every non-power-of-two position above 0, ascending.
  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] cw);
    logic [CODE_W-1:0] sh;
    int j;
    extract = '0;
    j = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        sh = cw >> i;
        if (sh[0]) extract = extract | (DATA_W'(1) << j);
        j++;
      end
    end
  endfunction

  localparam logic [CODE_W-1:0] MASK0 = cover_mask(0);
  localparam logic [CODE_W-1:0] MASK1 = cover_mask(1);
  localparam logic [CODE_W-1:0] MASK2 = cover_mask(2);
  localparam logic [CODE_W-1:0] MASK3 = cover_mask(3);
  localparam logic [CODE_W-1:0] MASK4 = cover_mask(4);

  logic [4:0]        syndrome;
  logic              parity;
  logic [CODE_W-1:0] corrected;
  logic [DATA_W-1:0] dec_data;
  logic              dec_sbe;
  logic              dec_dbe;

  always_comb begin
    syndrome[0] = ^(mem_rd_data & MASK0);
    syndrome[1] = ^(mem_rd_data & MASK1);
    syndrome[2] = ^(mem_rd_data & MASK2);
    syndrome[3] = ^(mem_rd_data & MASK3);
    syndrome[4] = ^(mem_rd_data & MASK4);
    parity      = ^mem_rd_data;
    corrected   = mem_rd_data;
    dec_sbe     = 1'b0;
    dec_dbe     = 1'b0;
    if (parity) begin
      if (syndrome == 5'd0) begin
        dec_sbe = 1'b1;
      end else if (syndrome <= 5'd21) begin
        corrected = mem_rd_data ^ (CODE_W'(1) << syndrome);
        dec_sbe   = 1'b1;
      end else begin
        dec_dbe = 1'b1;
      end
    end else if (syndrome != 5'd0) begin
      dec_dbe = 1'b1;
    end
    dec_data = extract(corrected);
  end

  logic [DATA_W-1:0] buf_data [2];
  logic [1:0]        buf_sbe;
  logic [1:0]        buf_dbe;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;
  logic              inflight;
  logic              push;
  logic              pop;
  logic [2:0]        credit;

  // Credit counts buffered words plus the read still in flight, so a
  // returning word always has a free slot.
  always_comb begin
    pop        = m_valid & m_ready;
    push       = inflight;
    credit     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd_en = rst_n & ~fifo_empty & (credit < 3'd2);
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_data[rd_ptr];
  assign m_sbe   = buf_sbe[rd_ptr];
  assign m_dbe   = buf_dbe[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_sbe     <= '0;
      buf_dbe     <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      inflight    <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (push) begin
        buf_data[wr_ptr] <= dec_data;
        buf_sbe[wr_ptr]  <= dec_sbe;
        buf_dbe[wr_ptr]  <= dec_dbe;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  // Error counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbe_count <= '0;
      dbe_count <= '0;
    end else if (pop) begin
      if (m_sbe && (sbe_count != '1)) sbe_count <= sbe_count + 1'b1;
      if (m_dbe && (dbe_count != '1)) dbe_count <= dbe_count + 1'b1;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && (occ == 2'd2)));

endmodule

// File: tb/tb_fifo_rd_port.sv
// Directed bench for fifo_rd_port: a behavioural FIFO/memory model feeds
// encoded words, a monitor records popped beats, the main thread checks them.
module tb_fifo_rd_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [21:0] mem_rd_data = '0;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_sbe;
  logic        m_dbe;
  logic [7:0]  sbe_count;
  logic [7:0]  dbe_count;

  int checks = 0;
  int errors = 0;

  logic [21:0] store [0:1023];
  int          wr_count = 0;
  int          rd_count = 0;

  logic [15:0] exp_data [0:1023];
  logic        exp_sbe  [0:1023];
  logic        exp_dbe  [0:1023];
  int          exp_wr  = 0;
  int          chk_idx = 0;

  logic [15:0] got_data [0:1023];
  logic        got_sbe  [0:1023];
  logic        got_dbe  [0:1023];
  int          got_cnt = 0;

  fifo_rd_port #(.DATA_W(16), .CODE_W(22), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .mem_rd_data (mem_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_sbe       (m_sbe),
    .m_dbe       (m_dbe),
    .sbe_count   (sbe_count),
    .dbe_count   (dbe_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_count == rd_count);

  // FIFO controller and registered memory: shares rst_n, so reset drops its contents.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= wr_count;
    end else if (fifo_rd_en) begin
      mem_rd_data <= store[rd_count];
      rd_count    <= rd_count + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      got_data[got_cnt] <= m_data;
      got_sbe[got_cnt]  <= m_sbe;
      got_dbe[got_cnt]  <= m_dbe;
      got_cnt           <= got_cnt + 1;
    end
  end

  function automatic logic [21:0] encode(input logic [15:0] d);
    int          dpos [16] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};
    logic [21:0] c;
    logic        x;
    c = '0;
    for (int b = 0; b < 16; b++) c[dpos[b]] = d[b];
    for (int k = 0; k < 5; k++) begin
      x = 1'b0;
      for (int i = 1; i < 22; i++) if (((i >> k) & 1) == 1) x = x ^ c[i];
      c[1 << k] = x;
    end
    c[0] = ^c[21:1];
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] data, input logic [21:0] flip,
                               input logic [15:0] e_data, input logic e_sbe, input logic e_dbe);
    store[wr_count]  = encode(data) ^ flip;
    exp_data[exp_wr] = e_data;
    exp_sbe[exp_wr]  = e_sbe;
    exp_dbe[exp_wr]  = e_dbe;
    exp_wr++;
    wr_count++;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBeats();
    while (chk_idx < got_cnt && chk_idx < exp_wr) begin
      checkOutput($sformatf("beat%0d_data", chk_idx), 32'(got_data[chk_idx]), 32'(exp_data[chk_idx]));
      checkOutput($sformatf("beat%0d_sbe", chk_idx), 32'(got_sbe[chk_idx]), 32'(exp_sbe[chk_idx]));
      checkOutput($sformatf("beat%0d_dbe", chk_idx), 32'(got_dbe[chk_idx]), 32'(exp_dbe[chk_idx]));
      chk_idx++;
    end
  endtask

  task automatic waitIdle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (got_cnt >= exp_wr && !m_valid && fifo_empty) break;
    end
    checkOutput("drain_count", 32'(got_cnt), 32'(exp_wr));
    checkOutput("drain_valid", 32'(m_valid), 32'd0);
    checkBeats();
  endtask

  initial begin
    rst_n   = 1'b0;
    m_ready = 1'b1;
    nextCycle();
    nextCycle();
    store[wr_count] = encode(16'hBEEF);
    wr_count++;
    #1;
    checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("rst_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_data", 32'(m_data), 32'd0);
    checkOutput("rst_sbe_cnt", 32'(sbe_count), 32'd0);
    checkOutput("rst_dbe_cnt", 32'(dbe_count), 32'd0);
    nextCycle();
    rst_n = 1'b1;

    $display("[TB] idle after reset");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_rd_en", 32'(fifo_rd_en), 32'd0);
      checkOutput("idle_valid", 32'(m_valid), 32'd0);
      checkOutput("idle_sbe_cnt", 32'(sbe_count), 32'd0);
      checkOutput("idle_dbe_cnt", 32'(dbe_count), 32'd0);
    end

    $display("[TB] 16 clean words, streaming");
    nextCycle();
    for (int k = 0; k < 16; k++) applyStimulus(16'(k), 22'h0, 16'(k), 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lat_rd_en_n0", 32'(fifo_rd_en), 32'd1);
    checkOutput("lat_valid_n0", 32'(m_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_valid_n1", 32'(m_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_valid_n2", 32'(m_valid), 32'd1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      checkOutput("stream_valid", 32'(m_valid), 32'd1);
    end
    @(negedge clk);
    checkOutput("stream_end", 32'(m_valid), 32'd0);
    waitIdle(50);
    checkOutput("clean_sbe_cnt", 32'(sbe_count), 32'd0);
    checkOutput("clean_dbe_cnt", 32'(dbe_count), 32'd0);

    $display("[TB] single and double bit errors");
    nextCycle();
    applyStimulus(16'hA5A5, 22'h1 << 9, 16'hA5A5, 1'b1, 1'b0);
    waitIdle(50);
    checkOutput("sbe9_cnt", 32'(sbe_count), 32'd1);
    nextCycle();
    applyStimulus(16'hA5A5, 22'h1, 16'hA5A5, 1'b1, 1'b0);
    waitIdle(50);
    checkOutput("sbe0_cnt", 32'(sbe_count), 32'd2);
    nextCycle();
    applyStimulus(16'h1234, (22'h1 << 3) | (22'h1 << 12), 16'h12B5, 1'b0, 1'b1);
    waitIdle(50);
    checkOutput("dbe_cnt", 32'(dbe_count), 32'd1);
    checkOutput("dbe_sbe_cnt", 32'(sbe_count), 32'd2);

    $display("[TB] backpressure");
    nextCycle();
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) applyStimulus(16'h0100 + 16'(k), 22'h0, 16'h0100 + 16'(k), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        checkOutput("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("bp_valid", 32'(m_valid), 32'd1);
        checkOutput("bp_data", 32'(m_data), 32'h0100);
        checkOutput("bp_sbe", 32'(m_sbe), 32'd0);
      end
    end
    nextCycle();
    m_ready = 1'b1;
    waitIdle(50);

    $display("[TB] reset with a read in flight");
    nextCycle();
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(16'h0200 + 16'(k), 22'h0, 16'h0200 + 16'(k), 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("pre_rst_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("mid_rst_sbe_cnt", 32'(sbe_count), 32'd0);
    nextCycle();
    nextCycle();
    exp_wr  = got_cnt;
    chk_idx = got_cnt;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("post_rst_valid", 32'(m_valid), 32'd0);
      checkOutput("post_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    end
    checkOutput("post_rst_beats", 32'(got_cnt), 32'(exp_wr));

    $display("[TB] counter saturation");
    nextCycle();
    for (int k = 0; k < 300; k++)
      applyStimulus(16'(k * 7 + 3), 22'h1 << (k % 22), 16'(k * 7 + 3), 1'b1, 1'b0);
    waitIdle(2000);
    checkOutput("sat_sbe_cnt", 32'(sbe_count), 32'd255);
    checkOutput("sat_dbe_cnt", 32'(dbe_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
